// File: rtl/ff_bist_pkg.sv
// ff_bist_pkg
// Shared types and constants for the flip-flop BIST controller.
//   state_e       : sequencer states
//   LFSR_W        : width of the pattern generator
//   LFSR_TAPS     : Fibonacci tap mask (taps 8,6,5,4)
//   DEFAULT_SEED  : LFSR load value used when no seed is supplied
//   fixSeed()     : maps an all-zero seed (LFSR lock-up) to 8'h01
package ff_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_DRIVE,
        ST_CHECK,
        ST_RSTCHK_A,
        ST_RSTCHK_C,
        ST_DONE
    } state_e;

    localparam int               LFSR_W       = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'hB8;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

    // An all-zero Fibonacci LFSR never leaves zero, so it is never used as a seed.
    function automatic logic [LFSR_W-1:0] fixSeed(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? 8'h01 : seed;
    endfunction

endpackage

// File: rtl/ff_bist_lfsr.sv
// ff_bist_lfsr
// 8-bit Fibonacci LFSR used as the BIST data source. Shifts left with the
// XOR of the tapped bits fed into bit 0.
// Ports:
//   clk       : clock, rising edge
//   rstn      : asynchronous active-low reset (loads the seed)
//   load_i    : reload the seed on the next edge (wins over advance_i)
//   advance_i : step the register once on the next edge
//   state_o   : current register contents
module ff_bist_lfsr
    import ff_bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_i,
    input  logic              advance_i,
    output logic [LFSR_W-1:0] state_o
);

    localparam logic [LFSR_W-1:0] SEED_EFF = fixSeed(SEED);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next value: reload has priority, otherwise one Fibonacci step when asked.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED_EFF;
        end else if (advance_i) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // State register; reset leaves the generator ready at the seed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/ff_bist_ctrl.sv
// ff_bist_ctrl
// BIST sequencer for one flip-flop under test (FUT) and a golden reference
// flip-flop fed from the same stimulus. A run resets both flops, applies
// NUM_VECTORS LFSR data vectors (drive one cycle, compare the next), then
// asserts the local reset and checks both flops read q=0/qbar=1.
// Optional feature macro: FF_BIST_FIRST_FAIL_EN adds first_fail_idx/_vld,
// the index of the first failing check in a run (NUM_VECTORS = reset check).
// Ports:
//   clk, rstn           : clock (rising edge), async active-low reset
//   start               : run request, only honoured in IDLE
//   busy, done, pass    : status; done is a one-cycle pulse, pass is held
//   err_cnt             : saturating mismatch count of the current/last run
//   dut_d, dut_rstn     : data and local reset driven to both flops
//   dut_q/dut_qbar      : FUT outputs
//   gold_q/gold_qbar    : golden outputs
module ff_bist_ctrl
    import ff_bist_pkg::*;
#(
    parameter int                NUM_VECTORS = 20,
    parameter int                RST_CYCLES  = 2,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = DEFAULT_SEED,
    parameter int                ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 dut_d,
    output logic                 dut_rstn,
    input  logic                 dut_q,
    input  logic                 dut_qbar,
    input  logic                 gold_q,
    input  logic                 gold_qbar
`ifdef FF_BIST_FIRST_FAIL_EN
    ,
    output logic [7:0]           first_fail_idx,
    output logic                 first_fail_vld
`endif
);

    localparam logic [15:0] NV      = 16'(NUM_VECTORS);
    localparam logic [15:0] RC_LAST = 16'(RST_CYCLES - 1);
    // The vector bit is the LFSR's bit-0 output tap.
    localparam logic [LFSR_W-1:0] OUT_TAP = 8'h01;

    state_e               state_q;
    logic [15:0]          cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 dutD_q;
    logic                 dutRstn_q;
    logic [ERR_CNT_W-1:0] errCnt_q;
    logic [ERR_CNT_W-1:0] errCnt_d;

    logic                 pairMismatch;
    logic                 rstMismatch;
    logic                 checkFail;
    logic                 lastVector;
    logic                 rstDone;
    logic                 lfsrLoad;
    logic                 lfsrAdvance;
    logic [LFSR_W-1:0]    lfsrState;

    assign lastVector  = (cnt_q + 16'd1) == NV;
    assign rstDone     = cnt_q == RC_LAST;
    assign lfsrLoad    = (state_q == ST_IDLE) && start;
    // Step the LFSR exactly on the edges that enter DRIVE, after its bit is taken.
    assign lfsrAdvance = ((state_q == ST_RST) && rstDone) ||
                         ((state_q == ST_CHECK) && !lastVector);

    ff_bist_lfsr #(
        .SEED      (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rstn      (rstn),
        .load_i    (lfsrLoad),
        .advance_i (lfsrAdvance),
        .state_o   (lfsrState)
    );

    // Compare logic and the saturating error count. The reset check also
    // requires the FUT to read q=0/qbar=1; any failure costs a single count.
    always_comb begin
        pairMismatch = (dut_q != gold_q) | (dut_qbar != gold_qbar);
        rstMismatch  = dut_q | ~dut_qbar;
        checkFail    = ((state_q == ST_CHECK) && pairMismatch) ||
                       ((state_q == ST_RSTCHK_C) && (pairMismatch || rstMismatch));
        errCnt_d     = errCnt_q;
        if (checkFail && !(&errCnt_q)) begin
            errCnt_d = errCnt_q + 1'b1;
        end
    end

    // Sequencer. Every output register is loaded on the edge that enters the
    // state it belongs to, so outputs follow the state with no input paths.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            errCnt_q  <= '0;
            dutD_q    <= 1'b0;
            dutRstn_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            errCnt_q <= errCnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RST;
                        busy_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        errCnt_q  <= '0;
                        cnt_q     <= '0;
                        dutD_q    <= 1'b0;
                        dutRstn_q <= 1'b0;
                    end
                end
                ST_RST: begin
                    if (rstDone) begin
                        state_q   <= ST_DRIVE;
                        cnt_q     <= '0;
                        dutRstn_q <= 1'b1;
                        dutD_q    <= |(lfsrState & OUT_TAP);
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_DRIVE: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    // cnt_q ends at NUM_VECTORS, which doubles as the reset-check index.
                    cnt_q <= cnt_q + 16'd1;
                    if (lastVector) begin
                        state_q   <= ST_RSTCHK_A;
                        dutRstn_q <= 1'b0;
                    end else begin
                        state_q <= ST_DRIVE;
                        dutD_q  <= |(lfsrState & OUT_TAP);
                    end
                end
                ST_RSTCHK_A: begin
                    state_q <= ST_RSTCHK_C;
                end
                ST_RSTCHK_C: begin
                    state_q   <= ST_DONE;
                    done_q    <= 1'b1;
                    pass_q    <= (errCnt_d == '0);
                    dutRstn_q <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = errCnt_q;
    assign dut_d    = dutD_q;
    assign dut_rstn = dutRstn_q;

`ifdef FF_BIST_FIRST_FAIL_EN
    logic [7:0] firstFailIdx_q;
    logic       firstFailVld_q;

    // Latch the index of the first failing check; later failures are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            firstFailIdx_q <= '0;
            firstFailVld_q <= 1'b0;
        end else if (lfsrLoad) begin
            firstFailIdx_q <= '0;
            firstFailVld_q <= 1'b0;
        end else if (checkFail && !firstFailVld_q) begin
            firstFailIdx_q <= cnt_q[7:0];
            firstFailVld_q <= 1'b1;
        end
    end

    assign first_fail_idx = firstFailIdx_q;
    assign first_fail_vld = firstFailVld_q;
`endif

endmodule

// File: tb/tb_ff_bist_ctrl.sv
// tb_ff_bist_ctrl
// Directed bench for ff_bist_ctrl. Two controllers share stimulus: one with
// default parameters and one with a 3-bit error counter. The FUT is modelled
// as a correct DFF, an inverted DFF, or a DFF that ignores its reset.
// Cycle numbering: cycle n is the interval after the (n-1)th rising edge
// following the edge that samples start (the sampling edge is edge 0).
module tb_ff_bist_ctrl;

    logic       clk;
    logic       rstn;
    logic       start;

    logic       busy, done, pass, dutD, dutRstn;
    logic [7:0] errCnt;
    logic       busy2, done2, pass2, dutD2, dutRstn2;
    logic [2:0] errCnt2;

    logic       goldQ;
    logic       stuckQ;
    logic       futQ;
    logic [1:0] fMode;

    int         checkCount;
    int         passCount;
    int         failCount;

    int         doneCount;
    int         doneCycle;
    logic       busyAtStart;
    logic       busyAfterDone;
    logic [19:0] seenSeq;

`ifdef FF_BIST_FIRST_FAIL_EN
    logic [7:0] ffIdx, ffIdx2;
    logic       ffVld, ffVld2;
`endif

    ff_bist_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (errCnt),
        .dut_d     (dutD),
        .dut_rstn  (dutRstn),
        .dut_q     (futQ),
        .dut_qbar  (~futQ),
        .gold_q    (goldQ),
        .gold_qbar (~goldQ)
`ifdef FF_BIST_FIRST_FAIL_EN
        ,
        .first_fail_idx (ffIdx),
        .first_fail_vld (ffVld)
`endif
    );

    ff_bist_ctrl #(
        .ERR_CNT_W (3)
    ) dut2 (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .err_cnt   (errCnt2),
        .dut_d     (dutD2),
        .dut_rstn  (dutRstn2),
        .dut_q     (futQ),
        .dut_qbar  (~futQ),
        .gold_q    (goldQ),
        .gold_qbar (~goldQ)
`ifdef FF_BIST_FIRST_FAIL_EN
        ,
        .first_fail_idx (ffIdx2),
        .first_fail_vld (ffVld2)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Golden flop: plain DFF with async active-low reset from the controller.
    always @(posedge clk or negedge dutRstn) begin
        if (!dutRstn) goldQ <= 1'b0;
        else          goldQ <= dutD;
    end

    // Faulty flop variant that never sees its reset.
    always @(posedge clk) begin
        stuckQ <= dutD;
    end

    // FUT selection: 0 = correct, 1 = inverted outputs, 2 = ignores reset.
    always_comb begin
        futQ = goldQ;
        if (fMode == 2'd1) futQ = ~goldQ;
        else if (fMode == 2'd2) futQ = stuckQ;
    end

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start (or hold it for holdCycles cycles) and watch the run for
    // numCycles cycles, recording done pulses, busy and the dut_d vectors.
    task automatic applyStimulus(input int holdCycles, input int numCycles);
        doneCount     = 0;
        doneCycle     = 0;
        busyAtStart   = 1'b0;
        busyAfterDone = 1'b1;
        seenSeq       = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= numCycles; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            if (cyc > holdCycles) start = 1'b0;
            if (cyc == 1) busyAtStart = busy;
            if (cyc == 46) busyAfterDone = busy;
            if (done) begin
                doneCount++;
                if (doneCycle == 0) doneCycle = cyc;
            end
            if (cyc >= 3 && cyc <= 41 && (cyc % 2) == 1) seenSeq[(cyc - 3) / 2] = dutD;
        end
        start = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        rstn  = 1'b0;
        start = 1'b0;
        fMode = 2'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_err", 32'(errCnt), 32'd0);
        checkOutput("rst_dut_rstn", 32'(dutRstn), 32'd0);
        checkOutput("rst_dut_d", 32'(dutD), 32'd0);
`ifdef FF_BIST_FIRST_FAIL_EN
        checkOutput("rst_ff_vld", 32'(ffVld), 32'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Run 1: healthy FUT. dut_d must follow the LFSR from 8'hA5:
        // vectors 0..19 = 1,0,1,0,0,1,1,1,0,1,1,1,0,1,1,0,0,1,1,1.
        fMode = 2'd0;
        applyStimulus(0, 50);
        checkOutput("ok_busy_start", 32'(busyAtStart), 32'd1);
        checkOutput("ok_done_cycle", 32'(doneCycle), 32'd45);
        checkOutput("ok_done_count", 32'(doneCount), 32'd1);
        checkOutput("ok_busy_after", 32'(busyAfterDone), 32'd0);
        checkOutput("ok_pass", 32'(pass), 32'd1);
        checkOutput("ok_err", 32'(errCnt), 32'd0);
        checkOutput("ok_err_w3", 32'(errCnt2), 32'd0);
        checkOutput("ok_dut_d_seq", 32'(seenSeq), 32'h000E6EE5);
        checkOutput("ok_dut_rstn_idle", 32'(dutRstn), 32'd1);
`ifdef FF_BIST_FIRST_FAIL_EN
        checkOutput("ok_ff_vld", 32'(ffVld), 32'd0);
`endif

        // Run 2: inverted FUT fails all 20 vectors plus the reset check.
        fMode = 2'd1;
        applyStimulus(0, 50);
        checkOutput("inv_done_cycle", 32'(doneCycle), 32'd45);
        checkOutput("inv_err", 32'(errCnt), 32'd21);
        checkOutput("inv_pass", 32'(pass), 32'd0);
        checkOutput("inv_err_w3_sat", 32'(errCnt2), 32'd7);
        checkOutput("inv_pass_w3", 32'(pass2), 32'd0);
`ifdef FF_BIST_FIRST_FAIL_EN
        checkOutput("inv_ff_idx", 32'(ffIdx), 32'd0);
        checkOutput("inv_ff_vld", 32'(ffVld), 32'd1);
`endif

        // Run 3: FUT ignores reset and holds the last vector (1).
        fMode = 2'd2;
        applyStimulus(0, 50);
        checkOutput("norst_err", 32'(errCnt), 32'd1);
        checkOutput("norst_pass", 32'(pass), 32'd0);
        checkOutput("norst_err_w3", 32'(errCnt2), 32'd1);
`ifdef FF_BIST_FIRST_FAIL_EN
        checkOutput("norst_ff_idx", 32'(ffIdx), 32'd20);
        checkOutput("norst_ff_vld", 32'(ffVld), 32'd1);
`endif

        // Run 4: inverted FUT, reset pulsed while vector 5 is being driven
        // (cycle 13; vectors 0..4 already counted as errors).
        fMode = 2'd1;
        applyStimulus(0, 13);
        checkOutput("mid_err_before", 32'(errCnt), 32'd5);
        checkOutput("mid_busy_before", 32'(busy), 32'd1);
        rstn = 1'b0;
        #2;
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_dut_rstn", 32'(dutRstn), 32'd0);
        checkOutput("mid_err", 32'(errCnt), 32'd0);
        checkOutput("mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (done) doneCount++;
        end
        checkOutput("mid_no_done", 32'(doneCount), 32'd0);

        // Run 5: fresh run after the aborted one.
        fMode = 2'd0;
        applyStimulus(0, 50);
        checkOutput("fresh_done_cycle", 32'(doneCycle), 32'd45);
        checkOutput("fresh_pass", 32'(pass), 32'd1);
        checkOutput("fresh_err", 32'(errCnt), 32'd0);

        // Run 6: start held high for 40 cycles while busy.
        applyStimulus(40, 50);
        checkOutput("hold_done_count", 32'(doneCount), 32'd1);
        checkOutput("hold_done_cycle", 32'(doneCycle), 32'd45);
        checkOutput("hold_pass", 32'(pass), 32'd1);
        checkOutput("hold_busy_after", 32'(busyAfterDone), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
